// File: rtl/scan_pkg.sv
// Shared state encoding and sizing helpers for the scan chain sequencer.
package scan_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CAPTURE = 3'd1,
        ST_LOAD    = 3'd2,
        ST_SHIFT   = 3'd3,
        ST_FLUSH   = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    // Number of host words needed to cover the whole chain.
    function automatic int unsigned num_words(input int unsigned chain_len,
                                              input int unsigned word_w);
        return (chain_len + word_w - 32'd1) / word_w;
    endfunction

    // Bits carried by the final (possibly partial) word.
    function automatic int unsigned last_word_len(input int unsigned chain_len,
                                                  input int unsigned word_w);
        return chain_len - (num_words(chain_len, word_w) - 32'd1) * word_w;
    endfunction

    // Counter width able to index n values, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 32'd1) ? $clog2(n) : 32'd1;
    endfunction

endpackage

// File: rtl/scan_chain_ctrl_if.sv
// Host-side command / scan-in / scan-out handshake bundle.
interface scan_chain_ctrl_if #(
    parameter int unsigned WORD_W = 8
);
    logic              start_valid;
    logic              start_ready;
    logic              start_capture;
    logic [WORD_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              done;

    // Host side.
    modport master (
        output start_valid, start_capture, in_data, in_valid, out_ready,
        input  start_ready, in_ready, out_data, out_valid, busy, done
    );

    // Sequencer side.
    modport slave (
        input  start_valid, start_capture, in_data, in_valid, out_ready,
        output start_ready, in_ready, out_data, out_valid, busy, done
    );
endinterface

// File: rtl/scan_word_serdes.sv
// Word-wide in/out shift registers and bit counter for one scan word.
// Scan-out bits enter at the top of the active word length, so a partial
// last word comes out right-aligned with zeroed high bits.
module scan_word_serdes
    import scan_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = 40,
    parameter int unsigned WORD_W    = 8
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              load,
    input  logic              shift_en,
    input  logic              last_word,
    input  logic [WORD_W-1:0] load_data,
    input  logic              sout,
    output logic              sin,
    output logic [WORD_W-1:0] word_out,
    output logic              word_last_bit
);
    localparam int unsigned       LAST_LEN = last_word_len(CHAIN_LEN, WORD_W);
    localparam int unsigned       CNT_W    = cnt_width(WORD_W);
    localparam logic [CNT_W-1:0]  FULL_END = CNT_W'(WORD_W - 1);
    localparam logic [CNT_W-1:0]  LAST_END = CNT_W'(LAST_LEN - 1);
    localparam logic [WORD_W-1:0] FULL_TOP = WORD_W'(1) << (WORD_W - 1);
    localparam logic [WORD_W-1:0] LAST_TOP = WORD_W'(1) << (LAST_LEN - 1);

    logic [WORD_W-1:0] in_shift;
    logic [WORD_W-1:0] out_shift;
    logic [CNT_W-1:0]  bit_cnt;
    logic [WORD_W-1:0] top_bit;

    assign top_bit       = last_word ? LAST_TOP : FULL_TOP;
    assign word_last_bit = (bit_cnt == (last_word ? LAST_END : FULL_END));
    assign sin           = in_shift[0];
    assign word_out      = out_shift;

    // Load a fresh word, or shift one bit each way per enabled cycle.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            in_shift  <= '0;
            out_shift <= '0;
            bit_cnt   <= '0;
        end else if (load) begin
            in_shift  <= load_data;
            out_shift <= '0;
            bit_cnt   <= '0;
        end else if (shift_en) begin
            in_shift  <= in_shift >> 1;
            out_shift <= (out_shift >> 1) | (sout ? top_bit : '0);
            bit_cnt   <= bit_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/scan_chain_ctrl.sv
// Scan chain sequencer: optional capture, then word-wise shift out/in.
// Optional feature macro: SCAN_CHAIN_CAPTURE_EN enables the CAPTURE state.
module scan_chain_ctrl
    import scan_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = 40,
    parameter int unsigned WORD_W    = 8
) (
    input  logic             clk,
    input  logic             clr_n,
    scan_chain_ctrl_if.slave bus,
    output logic             scan_sen,
    output logic             scan_ce,
    output logic             scan_sin,
    input  logic             scan_sout
);
    localparam int unsigned      NW       = num_words(CHAIN_LEN, WORD_W);
    localparam int unsigned      IDX_W    = cnt_width(NW);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NW - 1);

    state_t            state;
    logic [IDX_W-1:0]  word_idx;
    logic              last_word;
    logic              word_last_bit;
    logic              serdes_load;
    logic              shift_en;
    logic [WORD_W-1:0] word_out;

    assign last_word   = (word_idx == LAST_IDX);
    assign serdes_load = bus.in_ready && bus.in_valid;
    assign shift_en    = (state == ST_SHIFT);
    assign bus.out_data = word_out;

`ifndef SCAN_CHAIN_CAPTURE_EN
    // Capture request is accepted on the bus but has no effect in this build.
    logic unused_capture;
    assign unused_capture = bus.start_capture;
`endif

    scan_word_serdes #(
        .CHAIN_LEN (CHAIN_LEN),
        .WORD_W    (WORD_W)
    ) u_serdes (
        .clk           (clk),
        .clr_n         (clr_n),
        .load          (serdes_load),
        .shift_en      (shift_en),
        .last_word     (last_word),
        .load_data     (bus.in_data),
        .sout          (scan_sout),
        .sin           (scan_sin),
        .word_out      (word_out),
        .word_last_bit (word_last_bit)
    );

    // Command sequencer; every output is set on the transition into its state.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state           <= ST_IDLE;
            word_idx        <= '0;
            bus.start_ready <= 1'b1;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.in_ready    <= 1'b0;
            bus.out_valid   <= 1'b0;
            scan_ce         <= 1'b0;
            scan_sen        <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start_valid && bus.start_ready) begin
                        word_idx        <= '0;
                        bus.start_ready <= 1'b0;
                        bus.busy        <= 1'b1;
`ifdef SCAN_CHAIN_CAPTURE_EN
                        if (bus.start_capture) begin
                            state    <= ST_CAPTURE;
                            scan_ce  <= 1'b1;
                            scan_sen <= 1'b0;
                        end else begin
                            state        <= ST_LOAD;
                            bus.in_ready <= 1'b1;
                        end
`else
                        state        <= ST_LOAD;
                        bus.in_ready <= 1'b1;
`endif
                    end
                end
`ifdef SCAN_CHAIN_CAPTURE_EN
                ST_CAPTURE: begin
                    state        <= ST_LOAD;
                    scan_ce      <= 1'b0;
                    bus.in_ready <= 1'b1;
                end
`endif
                ST_LOAD: begin
                    if (bus.in_valid) begin
                        state        <= ST_SHIFT;
                        bus.in_ready <= 1'b0;
                        scan_ce      <= 1'b1;
                        scan_sen     <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (word_last_bit) begin
                        state         <= ST_FLUSH;
                        scan_ce       <= 1'b0;
                        scan_sen      <= 1'b0;
                        bus.out_valid <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        if (last_word) begin
                            state    <= ST_DONE;
                            bus.done <= 1'b1;
                        end else begin
                            state        <= ST_LOAD;
                            word_idx     <= word_idx + IDX_W'(1);
                            bus.in_ready <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state           <= ST_IDLE;
                    bus.busy        <= 1'b0;
                    bus.start_ready <= 1'b1;
                end
                default: begin
                    state           <= ST_IDLE;
                    bus.busy        <= 1'b0;
                    bus.start_ready <= 1'b1;
                    bus.in_ready    <= 1'b0;
                    bus.out_valid   <= 1'b0;
                    scan_ce         <= 1'b0;
                    scan_sen        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Directed bench: two sequencers (40/8 and 12/8) each driving a modelled scan chain.
module tb_scan_chain_ctrl;

    logic clk = 1'b0;
    logic clr_n;
    always #5 clk = ~clk;

    scan_chain_ctrl_if #(.WORD_W(8)) ifa ();
    scan_chain_ctrl_if #(.WORD_W(8)) ifb ();

    logic sen_a, ce_a, sin_a, sout_a;
    logic sen_b, ce_b, sin_b, sout_b;

    scan_chain_ctrl #(.CHAIN_LEN(40), .WORD_W(8)) dut_a (
        .clk(clk), .clr_n(clr_n), .bus(ifa),
        .scan_sen(sen_a), .scan_ce(ce_a), .scan_sin(sin_a), .scan_sout(sout_a)
    );

    scan_chain_ctrl #(.CHAIN_LEN(12), .WORD_W(8)) dut_b (
        .clk(clk), .clr_n(clr_n), .bus(ifb),
        .scan_sen(sen_b), .scan_ce(ce_b), .scan_sin(sin_b), .scan_sout(sout_b)
    );

    // Host drives the selected sequencer; the other sees an idle host.
    logic       sel;
    logic       h_start_valid, h_start_capture, h_in_valid, h_out_ready;
    logic [7:0] h_in_data;

    assign ifa.start_valid   = h_start_valid & ~sel;
    assign ifb.start_valid   = h_start_valid & sel;
    assign ifa.start_capture = h_start_capture;
    assign ifb.start_capture = h_start_capture;
    assign ifa.in_data       = h_in_data;
    assign ifb.in_data       = h_in_data;
    assign ifa.in_valid      = h_in_valid & ~sel;
    assign ifb.in_valid      = h_in_valid & sel;
    assign ifa.out_ready     = h_out_ready & ~sel;
    assign ifb.out_ready     = h_out_ready & sel;

    logic       m_start_ready, m_busy, m_done, m_in_ready, m_out_valid, m_ce, m_sen, m_sin;
    logic [7:0] m_out_data;

    assign m_start_ready = sel ? ifb.start_ready : ifa.start_ready;
    assign m_busy        = sel ? ifb.busy        : ifa.busy;
    assign m_done        = sel ? ifb.done        : ifa.done;
    assign m_in_ready    = sel ? ifb.in_ready    : ifa.in_ready;
    assign m_out_valid   = sel ? ifb.out_valid   : ifa.out_valid;
    assign m_out_data    = sel ? ifb.out_data    : ifa.out_data;
    assign m_ce          = sel ? ce_b  : ce_a;
    assign m_sen         = sel ? sen_b : sen_a;
    assign m_sin         = sel ? sin_b : sin_a;

    // ScanReg-style chain models: sout is bit 0, sin enters at the top.
    logic [39:0] chain_a, d_a, pre_val_a;
    logic [11:0] chain_b, pre_val_b;
    logic        pre_a, pre_b;

    always @(posedge clk) begin
        if (pre_a)     chain_a <= pre_val_a;
        else if (ce_a) chain_a <= sen_a ? {sin_a, chain_a[39:1]} : d_a;
        if (pre_b)     chain_b <= pre_val_b;
        else if (ce_b) chain_b <= sen_b ? {sin_b, chain_b[11:1]} : 12'h000;
    end
    assign sout_a = chain_a[0];
    assign sout_b = chain_b[0];

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] tx_words [0:4];
    logic [7:0] rx_words [0:4];
    logic [7:0] exp_words[0:4];

    task automatic preset_a(input logic [39:0] v);
        pre_val_a = v; pre_a = 1'b1;
        @(posedge clk); #1;
        pre_a = 1'b0;
    endtask

    task automatic preset_b(input logic [11:0] v);
        pre_val_b = v; pre_b = 1'b1;
        @(posedge clk); #1;
        pre_b = 1'b0;
    endtask

    task automatic set_tx(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                          input logic [7:0] w3, input logic [7:0] w4);
        tx_words[0] = w0; tx_words[1] = w1; tx_words[2] = w2; tx_words[3] = w3; tx_words[4] = w4;
        for (int i = 0; i < 5; i++) rx_words[i] = 8'hEE;
    endtask

    task automatic set_exp(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                           input logic [7:0] w3, input logic [7:0] w4);
        exp_words[0] = w0; exp_words[1] = w1; exp_words[2] = w2; exp_words[3] = w3; exp_words[4] = w4;
    endtask

    // Host driver for one command; stalls apply to out word 1 and in word 2.
    task automatic run_cmd(input logic cap, input logic hold_start,
                           input int out_stall, input int in_stall,
                           output int cycles, output int cap_cnt, output int shift_cnt,
                           output int stall_ce, output int ready_busy, output logic tmo);
        int   widx, ridx, wait_cnt;
        logic stalled;
        cycles = 0; cap_cnt = 0; shift_cnt = 0; stall_ce = 0; ready_busy = 0;
        widx = 0; ridx = 0; wait_cnt = 0;
        while (!m_start_ready && wait_cnt < 20) begin
            @(posedge clk); #1;
            wait_cnt++;
        end
        h_start_valid   = 1'b1;
        h_start_capture = cap;
        @(posedge clk); #1;
        if (!hold_start) h_start_valid = 1'b0;
        h_start_capture = 1'b0;
        cycles = 1;
        while (!m_done && cycles < 400) begin
            stalled     = 1'b0;
            h_in_valid  = 1'b0;
            h_out_ready = 1'b0;
            if (m_in_ready) begin
                if (widx == 2 && in_stall > 0) begin
                    in_stall--; stalled = 1'b1;
                end else if (widx < 5) begin
                    h_in_valid = 1'b1;
                    h_in_data  = tx_words[3'(widx)];
                    widx++;
                end
            end
            if (m_out_valid) begin
                if (ridx == 1 && out_stall > 0) begin
                    out_stall--; stalled = 1'b1;
                end else if (ridx < 5) begin
                    h_out_ready = 1'b1;
                    rx_words[3'(ridx)] = m_out_data;
                    ridx++;
                end
            end
            if (m_ce && !m_sen) cap_cnt++;
            if (m_ce && m_sen) shift_cnt++;
            if (stalled && m_ce) stall_ce++;
            if (m_busy && m_start_ready) ready_busy++;
            @(posedge clk); #1;
            cycles++;
        end
        tmo = !m_done;
        h_start_valid = 1'b0;
        h_in_valid    = 1'b0;
        h_out_ready   = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        sel = 1'b0; clr_n = 1'b0;
        h_start_valid = 0; h_start_capture = 0; h_in_valid = 0; h_out_ready = 0; h_in_data = 0;
        d_a = 40'h0; pre_val_a = 40'h0; pre_val_b = 12'h0; pre_a = 1'b1; pre_b = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        pre_a = 1'b0; pre_b = 1'b0;
        n_checks++; if (m_start_ready !== 1'b1) begin n_fail++; $display("FAIL reset_start_ready got %b want 1", m_start_ready); end
        n_checks++; if (m_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", m_busy); end
        n_checks++; if (m_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", m_done); end
        n_checks++; if (m_in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b want 0", m_in_ready); end
        n_checks++; if (m_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", m_out_valid); end
        n_checks++; if (m_out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data got %h want 00", m_out_data); end
        n_checks++; if ({m_ce, m_sen, m_sin} !== 3'b000) begin n_fail++; $display("FAIL reset_scan got %b want 000", {m_ce, m_sen, m_sin}); end
        n_checks++; if (ifb.start_ready !== 1'b1) begin n_fail++; $display("FAIL reset_b_start_ready got %b want 1", ifb.start_ready); end
        #2 clr_n = 1'b1;
        @(posedge clk); #1;
        n_checks++; if ({m_start_ready, m_busy} !== 2'b10) begin n_fail++; $display("FAIL post_reset_idle got %b want 10", {m_start_ready, m_busy}); end
    endtask

    task automatic test_basic();
        int cyc, capc, shc, stc, rb; logic tmo;
        sel = 1'b0;
        preset_a(40'h00_0000_00A5);
        set_tx(8'h11, 8'h22, 8'h33, 8'h44, 8'h55);
        set_exp(8'hA5, 8'h00, 8'h00, 8'h00, 8'h00);
        run_cmd(1'b0, 1'b0, 0, 0, cyc, capc, shc, stc, rb, tmo);
        n_checks++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL basic_timeout got %b want 0", tmo); end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (rx_words[i] !== exp_words[i]) begin n_fail++; $display("FAIL basic_out_word%0d got %h want %h", i, rx_words[i], exp_words[i]); end
        end
        n_checks++; if (chain_a !== 40'h55_4433_2211) begin n_fail++; $display("FAIL basic_chain got %h want 5544332211", chain_a); end
        n_checks++; if (cyc !== 51) begin n_fail++; $display("FAIL basic_latency got %0d want 51", cyc); end
        n_checks++; if (shc !== 40) begin n_fail++; $display("FAIL basic_shifts got %0d want 40", shc); end
        n_checks++; if (capc !== 0) begin n_fail++; $display("FAIL basic_capture_cycles got %0d want 0", capc); end
    endtask

    task automatic test_capture();
        int cyc, capc, shc, stc, rb; logic tmo;
        int exp_cyc, exp_cap;
        sel = 1'b0;
        d_a = 40'h12_3456_789A;
        preset_a(40'h01_0203_0405);
        set_tx(8'hA0, 8'hB1, 8'hC2, 8'hD3, 8'hE4);
`ifdef SCAN_CHAIN_CAPTURE_EN
        set_exp(8'h9A, 8'h78, 8'h56, 8'h34, 8'h12);
        exp_cyc = 52; exp_cap = 1;
`else
        set_exp(8'h05, 8'h04, 8'h03, 8'h02, 8'h01);
        exp_cyc = 51; exp_cap = 0;
`endif
        run_cmd(1'b1, 1'b0, 0, 0, cyc, capc, shc, stc, rb, tmo);
        n_checks++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL capture_timeout got %b want 0", tmo); end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (rx_words[i] !== exp_words[i]) begin n_fail++; $display("FAIL capture_out_word%0d got %h want %h", i, rx_words[i], exp_words[i]); end
        end
        n_checks++; if (capc !== exp_cap) begin n_fail++; $display("FAIL capture_cycles got %0d want %0d", capc, exp_cap); end
        n_checks++; if (cyc !== exp_cyc) begin n_fail++; $display("FAIL capture_latency got %0d want %0d", cyc, exp_cyc); end
        n_checks++; if (chain_a !== 40'hE4_D3C2_B1A0) begin n_fail++; $display("FAIL capture_chain got %h want E4D3C2B1A0", chain_a); end
    endtask

    task automatic test_partial();
        int cyc, capc, shc, stc, rb; logic tmo;
        sel = 1'b1;
        preset_b(12'hABC);
        set_tx(8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00);
        run_cmd(1'b0, 1'b0, 0, 0, cyc, capc, shc, stc, rb, tmo);
        n_checks++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL partial_timeout got %b want 0", tmo); end
        n_checks++; if (rx_words[0] !== 8'hBC) begin n_fail++; $display("FAIL partial_word0 got %h want BC", rx_words[0]); end
        n_checks++; if (rx_words[1] !== 8'h0A) begin n_fail++; $display("FAIL partial_word1 got %h want 0A", rx_words[1]); end
        n_checks++; if (rx_words[2] !== 8'hEE) begin n_fail++; $display("FAIL partial_extra_word got %h want EE", rx_words[2]); end
        n_checks++; if (chain_b !== 12'hFFF) begin n_fail++; $display("FAIL partial_chain got %h want FFF", chain_b); end
        n_checks++; if (shc !== 12) begin n_fail++; $display("FAIL partial_shifts got %0d want 12", shc); end
        n_checks++; if (cyc !== 17) begin n_fail++; $display("FAIL partial_latency got %0d want 17", cyc); end
        sel = 1'b0;
    endtask

    task automatic test_stall();
        int cyc, capc, shc, stc, rb; logic tmo;
        sel = 1'b0;
        preset_a(40'h00_0000_00A5);
        set_tx(8'h11, 8'h22, 8'h33, 8'h44, 8'h55);
        set_exp(8'hA5, 8'h00, 8'h00, 8'h00, 8'h00);
        run_cmd(1'b0, 1'b0, 10, 5, cyc, capc, shc, stc, rb, tmo);
        n_checks++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL stall_timeout got %b want 0", tmo); end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (rx_words[i] !== exp_words[i]) begin n_fail++; $display("FAIL stall_out_word%0d got %h want %h", i, rx_words[i], exp_words[i]); end
        end
        n_checks++; if (chain_a !== 40'h55_4433_2211) begin n_fail++; $display("FAIL stall_chain got %h want 5544332211", chain_a); end
        n_checks++; if (stc !== 0) begin n_fail++; $display("FAIL stall_ce_active got %0d want 0", stc); end
        n_checks++; if (shc !== 40) begin n_fail++; $display("FAIL stall_shifts got %0d want 40", shc); end
        n_checks++; if (cyc !== 66) begin n_fail++; $display("FAIL stall_latency got %0d want 66", cyc); end
    endtask

    task automatic test_abort();
        int cyc, capc, shc, stc, rb, n; logic tmo;
        sel = 1'b0;
        preset_a(40'h00_0000_00A5);
        h_start_valid = 1'b1;
        @(posedge clk); #1;
        h_start_valid = 1'b0;
        h_in_valid = 1'b1; h_in_data = 8'hFF;
        n = 0;
        while (!(m_ce && m_sen) && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        h_in_valid = 1'b0;
        n_checks++; if (n >= 20) begin n_fail++; $display("FAIL abort_reach_shift got %0d cycles want <20", n); end
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if ({m_ce, m_sen, m_sin} !== 3'b111) begin n_fail++; $display("FAIL abort_pre_scan got %b want 111", {m_ce, m_sen, m_sin}); end
        #2 clr_n = 1'b0;
        #1;
        n_checks++; if ({m_start_ready, m_busy, m_done} !== 3'b100) begin n_fail++; $display("FAIL abort_status got %b want 100", {m_start_ready, m_busy, m_done}); end
        n_checks++; if ({m_in_ready, m_out_valid} !== 2'b00) begin n_fail++; $display("FAIL abort_handshake got %b want 00", {m_in_ready, m_out_valid}); end
        n_checks++; if ({m_ce, m_sen, m_sin} !== 3'b000) begin n_fail++; $display("FAIL abort_scan got %b want 000", {m_ce, m_sen, m_sin}); end
        n_checks++; if (m_out_data !== 8'h00) begin n_fail++; $display("FAIL abort_out_data got %h want 00", m_out_data); end
        @(posedge clk);
        #2 clr_n = 1'b1;
        @(posedge clk); #1;
        preset_a(40'h00_0000_00A5);
        set_tx(8'h11, 8'h22, 8'h33, 8'h44, 8'h55);
        run_cmd(1'b0, 1'b0, 0, 0, cyc, capc, shc, stc, rb, tmo);
        n_checks++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL abort_rerun_timeout got %b want 0", tmo); end
        n_checks++; if (rx_words[0] !== 8'hA5) begin n_fail++; $display("FAIL abort_rerun_word0 got %h want A5", rx_words[0]); end
        n_checks++; if (chain_a !== 40'h55_4433_2211) begin n_fail++; $display("FAIL abort_rerun_chain got %h want 5544332211", chain_a); end
        n_checks++; if (cyc !== 51) begin n_fail++; $display("FAIL abort_rerun_latency got %0d want 51", cyc); end
    endtask

    task automatic test_start_held();
        int cyc, capc, shc, stc, rb; logic tmo;
        sel = 1'b0;
        preset_a(40'h00_0000_00A5);
        set_tx(8'h11, 8'h22, 8'h33, 8'h44, 8'h55);
        run_cmd(1'b0, 1'b1, 0, 0, cyc, capc, shc, stc, rb, tmo);
        n_checks++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL held_timeout got %b want 0", tmo); end
        n_checks++; if (cyc !== 51) begin n_fail++; $display("FAIL held_latency got %0d want 51", cyc); end
        n_checks++; if (rb !== 0) begin n_fail++; $display("FAIL held_ready_while_busy got %0d want 0", rb); end
        n_checks++; if (shc !== 40) begin n_fail++; $display("FAIL held_shifts got %0d want 40", shc); end
        @(posedge clk); #1;
        n_checks++; if ({m_start_ready, m_busy} !== 2'b10) begin n_fail++; $display("FAIL held_back_idle got %b want 10", {m_start_ready, m_busy}); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_capture();
        test_partial();
        test_stall();
        test_abort();
        test_start_held();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
